// File: rtl/sys_pkg.sv
// Shared types and helpers for the loop counter and systolic address generator.
package sys_pkg;

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic CntUp = 1'b1;
    localparam logic CntDn = 1'b0;

    localparam int unsigned MaxWidth = 16;

    // Callers zero-extend ld_val to MaxWidth and truncate the result to their own width.
    function automatic logic [MaxWidth-1:0] load_word(input logic [MaxWidth-1:0] val,
                                                      input int unsigned          shift);
        return val << shift;
    endfunction

endpackage

// File: rtl/sys_step_unit.sv
// Combinational +/-1 stepper with terminal-count compare.
module sys_step_unit
    import sys_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] term,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next,
    output logic             tc
);

    always_comb begin
        next = (up_dn == CntUp) ? count + WIDTH'(1) : count - WIDTH'(1);
        tc   = (count == term);
    end

endmodule

// File: rtl/sys_loop_counter.sv
// Loadable up/down loop counter with terminal stop or auto-reload.
module sys_loop_counter
    import sys_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned LDSHIFT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cnten,
    input  logic                 cntld,
    input  logic [WIDTH-LDSHIFT-1:0] ld_val,
    input  logic [WIDTH-1:0]     term,
    input  logic                 up_dn,
    input  logic                 reload_en,
    output logic [WIDTH-1:0]     count,
    output logic                 busy,
    output logic                 tc,
    output logic                 done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] ld_word;

    assign ld_word = WIDTH'(load_word(MaxWidth'(ld_val), LDSHIFT));

    sys_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .count (count_q),
        .term  (term),
        .up_dn (up_dn),
        .next  (step_next),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        // A terminal step pulses done even when a load wins the count update.
        done_d  = (state_q == StRun) && cnten && tc;
        if (cntld) begin
            count_d = ld_word;
            base_d  = ld_word;
            state_d = StRun;
        end else if ((state_q == StRun) && cnten) begin
            if (!tc) begin
                count_d = step_next;
            end else if (reload_en) begin
                count_d = base_q;
            end else begin
                state_d = StIdle;
            end
        end
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sys_loop_counter.sv
// Directed bench for sys_loop_counter: a WIDTH=6/LDSHIFT=1 and a WIDTH=4/LDSHIFT=0 instance.
module tb_sys_loop_counter;

    logic       clk = 1'b0;
    logic       reset;

    logic       cnten, cntld, up_dn, reload_en;
    logic [4:0] ld_val;
    logic [5:0] term;
    logic [5:0] count;
    logic       busy, tc, done;

    logic       cnten4, cntld4, up_dn4, reload_en4;
    logic [3:0] ld_val4, term4, count4;
    logic       busy4, tc4, done4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sys_loop_counter #(.WIDTH(6), .LDSHIFT(1)) u_dut (
        .clk (clk), .reset (reset), .cnten (cnten), .cntld (cntld), .ld_val (ld_val),
        .term (term), .up_dn (up_dn), .reload_en (reload_en), .count (count),
        .busy (busy), .tc (tc), .done (done)
    );

    sys_loop_counter #(.WIDTH(4), .LDSHIFT(0)) u_dut4 (
        .clk (clk), .reset (reset), .cnten (cnten4), .cntld (cntld4), .ld_val (ld_val4),
        .term (term4), .up_dn (up_dn4), .reload_en (reload_en4), .count (count4),
        .busy (busy4), .tc (tc4), .done (done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    int exp_c[8] = '{3, 2, 1, 4, 3, 2, 1, 4};
    int exp_d[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int wrap_c[4] = '{15, 0, 1, 2};

    initial begin
        reset = 1'b1;
        cnten = 0; cntld = 0; up_dn = 1; reload_en = 0; ld_val = '0; term = '0;
        cnten4 = 0; cntld4 = 0; up_dn4 = 1; reload_en4 = 0; ld_val4 = '0; term4 = '0;
        cycle(); cycle();
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tc", tc, 1);
        reset = 1'b0;
        cycle();

        // Up count, stop at terminal
        ld_val = 3; term = 10; up_dn = 1; reload_en = 0; cntld = 1; cnten = 1;
        cycle();
        check("ld_count", count, 6);
        check("ld_busy", busy, 1);
        check("ld_done", done, 0);
        cntld = 0;
        for (int i = 7; i <= 10; i++) begin
            cycle();
            check("up_count", count, i);
            check("up_done", done, 0);
        end
        check("up_tc", tc, 1);
        cycle();
        check("stop_count", count, 10);
        check("stop_busy", busy, 0);
        check("stop_done", done, 1);
        cycle();
        check("idle_count", count, 10);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_tc", tc, 1);

        // Down count with reload
        ld_val = 2; term = 1; up_dn = 0; reload_en = 1; cntld = 1; cnten = 0;
        cycle();
        check("dn_ld", count, 4);
        cntld = 0; cnten = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("dn_count", count, exp_c[i]);
            check("dn_done", done, exp_d[i]);
            check("dn_busy", busy, 1);
        end

        // Load coincident with a terminal step
        cnten = 0; reload_en = 0; up_dn = 1; ld_val = 5; term = 10; cntld = 1;
        cycle();
        check("sim_ld", count, 10);
        ld_val = 7; cnten = 1; cntld = 1;
        cycle();
        check("sim_count", count, 14);
        check("sim_done", done, 1);
        check("sim_busy", busy, 1);
        cntld = 0; cnten = 0;
        cycle();
        check("sim_count2", count, 14);
        check("sim_done2", done, 0);
        check("sim_busy2", busy, 1);

        // Enable gaps, then IDLE ignores cnten
        term = 17;
        cnten = 1; cycle(); check("gap1", count, 15);
        cnten = 0; cycle(); check("gap0", count, 15);
        cnten = 1; cycle(); check("gap2", count, 16);
        cycle(); check("gap3", count, 17);
        cycle();
        check("gap_stop", count, 17);
        check("gap_done", done, 1);
        check("gap_busy", busy, 0);
        cycle(); check("gap_idle", count, 17);
        cycle(); check("gap_idle2", count, 17);
        check("gap_idle_done", done, 0);
        ld_val = 1; cntld = 1; cycle(); cntld = 0;
        check("gap_reld", count, 2);
        check("gap_rebusy", busy, 1);

        // Reset mid-count
        cnten = 0; ld_val = 5; term = 63; up_dn = 1; cntld = 1;
        cycle();
        cntld = 0; cnten = 1;
        cycle(); cycle();
        check("mid_count", count, 12);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        cycle();
        check("mid_rst_done2", done, 0);
        check("mid_rst_count2", count, 0);
        reset = 1'b0; cnten = 0;
        cycle();
        check("mid_post_done", done, 0);
        check("mid_post_busy", busy, 0);

        // Wrap-around on the 4-bit instance
        ld_val4 = 14; term4 = 2; up_dn4 = 1; reload_en4 = 0; cntld4 = 1;
        cycle();
        check("wr_ld", count4, 14);
        cntld4 = 0; cnten4 = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("wr_count", count4, wrap_c[i]);
            check("wr_done", done4, 0);
        end
        cycle();
        check("wr_stop", count4, 2);
        check("wr_done_end", done4, 1);
        check("wr_busy", busy4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
